tl_sync_fifo: RTL and testbench

//  Parametrised single-clock FIFO; successor to the dual-clock FIFO for same-domain TileLink channel buffering.

---
 rtl/tl_fifo_pkg.sv | 7 +
 rtl/tl_fifo_ram.sv | 25 ++
 rtl/tl_sync_fifo.sv | 107 ++++++++++
 tb/tb_tl_sync_fifo.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/tl_fifo_pkg.sv
// Shared constants for the TileLink channel buffering blocks.
package tl_fifo_pkg;

    localparam int unsigned FIFO_MODE_STD  = 0;
    localparam int unsigned FIFO_MODE_FWFT = 1;

endpackage

// File: rtl/tl_fifo_ram.sv
// FIFO storage: one synchronous write port, one asynchronous read port, no reset.
module tl_fifo_ram #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/tl_sync_fifo.sv
// Single-clock FIFO with standard or first-word-fall-through read, flush,
// occupancy count, almost-full/empty thresholds and overflow/underflow pulses.
module tl_sync_fifo
    import tl_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = 8,
    parameter int unsigned DEPTH         = 8,
    parameter int unsigned FWFT          = FIFO_MODE_STD,
    parameter int unsigned AFULL_THRESH  = DEPTH - 2,
    parameter int unsigned AEMPTY_THRESH = 1,
    parameter int unsigned ADDR_WIDTH    = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  full,
    output logic                  almost_full,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  empty,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int unsigned PW = ADDR_WIDTH + 1;

    logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, count_q, count_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d, ram_rdata;
    logic                  rd_valid_q, rd_valid_d;
    logic                  overflow_q, overflow_d, underflow_q, underflow_d;
    logic                  full_w, empty_w, acc_wr, acc_rd;

    tl_fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk_i   (clk),
        .we_i    (acc_wr),
        .waddr_i (wr_ptr_q[ADDR_WIDTH-1:0]),
        .wdata_i (wr_data),
        .raddr_i (rd_ptr_q[ADDR_WIDTH-1:0]),
        .rdata_o (ram_rdata)
    );

    always_comb begin
        full_w      = (count_q == PW'(DEPTH));
        empty_w     = (count_q == '0);
        // flush suppresses both acceptance and the error pulses for its cycle
        acc_wr      = wr_en && !full_w  && !flush;
        acc_rd      = rd_en && !empty_w && !flush;
        overflow_d  = wr_en && full_w   && !flush;
        underflow_d = rd_en && empty_w  && !flush;
        wr_ptr_d    = wr_ptr_q + PW'(acc_wr);
        rd_ptr_d    = rd_ptr_q + PW'(acc_rd);
        count_d     = count_q + PW'(acc_wr) - PW'(acc_rd);
        rd_valid_d  = acc_rd;
        rd_data_d   = acc_rd ? ram_rdata : rd_data_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_valid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
        assign rd_data  = empty_w ? '0 : ram_rdata;
        assign rd_valid = !empty_w;
    end else begin : g_std
        assign rd_data  = rd_data_q;
        assign rd_valid = rd_valid_q;
    end

    assign full         = full_w;
    assign empty        = empty_w;
    assign almost_full  = (count_q >= PW'(AFULL_THRESH));
    assign almost_empty = (count_q <= PW'(AEMPTY_THRESH));
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

endmodule

// File: tb/tb_tl_sync_fifo.sv
// Directed and queue-scoreboarded checks of tl_sync_fifo; a standard-mode and a
// FWFT-mode instance share one stimulus stream.
module tb_tl_sync_fifo;

    logic       clk = 1'b0;
    logic       reset, flush, wr_en, rd_en;
    logic [7:0] wr_data;

    logic       s_full, s_afull, s_rvalid, s_empty, s_aempty, s_ov, s_un;
    logic [7:0] s_rdata;
    logic [3:0] s_count;
    logic       f_full, f_afull, f_rvalid, f_empty, f_aempty, f_ov, f_un;
    logic [7:0] f_rdata;
    logic [3:0] f_count;

    int unsigned errors = 0;
    int unsigned checks = 0;
    logic [7:0]  ref_q[$];
    logic [7:0]  last_std;

    always #5 clk = ~clk;

    tl_sync_fifo #(
        .DATA_WIDTH (8), .DEPTH (8), .FWFT (0), .AFULL_THRESH (6), .AEMPTY_THRESH (1)
    ) u_std (
        .clk (clk), .reset (reset), .flush (flush), .wr_en (wr_en), .wr_data (wr_data),
        .full (s_full), .almost_full (s_afull), .rd_en (rd_en), .rd_data (s_rdata),
        .rd_valid (s_rvalid), .empty (s_empty), .almost_empty (s_aempty), .count (s_count),
        .overflow (s_ov), .underflow (s_un)
    );

    tl_sync_fifo #(
        .DATA_WIDTH (8), .DEPTH (8), .FWFT (1), .AFULL_THRESH (6), .AEMPTY_THRESH (1)
    ) u_fwft (
        .clk (clk), .reset (reset), .flush (flush), .wr_en (wr_en), .wr_data (wr_data),
        .full (f_full), .almost_full (f_afull), .rd_en (rd_en), .rd_data (f_rdata),
        .rd_valid (f_rvalid), .empty (f_empty), .almost_empty (f_aempty), .count (f_count),
        .overflow (f_ov), .underflow (f_un)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0; reset = 1'b0;
    endtask

    // One cycle against the reference queue; expected values come from the queue state before the edge.
    task automatic op(input bit w, input bit r, input logic [7:0] d);
        int unsigned sz = ref_q.size();
        bit aw = w && (sz < 8);
        bit ar = r && (sz > 0);
        wr_en = w; rd_en = r; wr_data = d;
        step();
        if (ar) last_std = ref_q.pop_front();
        if (aw) ref_q.push_back(d);
        check_eq("m_count",  s_count, ref_q.size());
        check_eq("m_fcount", f_count, ref_q.size());
        check_eq("m_ovf",    s_ov, w && sz == 8);
        check_eq("m_unf",    s_un, r && sz == 0);
        check_eq("m_full",   s_full, ref_q.size() == 8);
        check_eq("m_empty",  s_empty, ref_q.size() == 0);
        check_eq("m_afull",  s_afull, ref_q.size() >= 6);
        check_eq("m_aempty", s_aempty, ref_q.size() <= 1);
        check_eq("m_svalid", s_rvalid, ar);
        check_eq("m_sdata",  s_rdata, last_std);
        check_eq("m_fvalid", f_rvalid, ref_q.size() > 0);
        check_eq("m_fdata",  f_rdata, (ref_q.size() > 0) ? ref_q[0] : 8'h00);
        wr_en = 1'b0; rd_en = 1'b0;
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0; wr_data = '0;
        step(); step();
        reset = 1'b0;

        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("rst_empty",  s_empty, 1);
            check_eq("rst_aempty", s_aempty, 1);
            check_eq("rst_full",   s_full, 0);
            check_eq("rst_count",  s_count, 0);
            check_eq("rst_svalid", s_rvalid, 0);
            check_eq("rst_sdata",  s_rdata, 0);
            check_eq("rst_fvalid", f_rvalid, 0);
            check_eq("rst_fdata",  f_rdata, 0);
        end

        // Fill 0x01..0x08, watching thresholds and the FWFT head
        for (int i = 1; i <= 8; i++) begin
            wr_en = 1'b1; wr_data = 8'(i);
            step();
            check_eq("fill_count",  s_count, i);
            check_eq("fill_afull",  s_afull, i >= 6);
            check_eq("fill_aempty", s_aempty, i <= 1);
            check_eq("fill_fdata",  f_rdata, 8'h01);
            check_eq("fill_fvalid", f_rvalid, 1);
        end
        check_eq("fill_full", s_full, 1);
        wr_data = 8'h09;
        step();
        check_eq("ovf_pulse", s_ov, 1);
        check_eq("ovf_fpulse", f_ov, 1);
        check_eq("ovf_count", s_count, 8);
        idle();
        step();
        check_eq("ovf_clear", s_ov, 0);

        for (int i = 1; i <= 8; i++) begin
            rd_en = 1'b1;
            step();
            check_eq("rd_svalid", s_rvalid, 1);
            check_eq("rd_sdata",  s_rdata, i);
            check_eq("rd_count",  s_count, 8 - i);
            check_eq("rd_fdata",  f_rdata, (i < 8) ? i + 1 : 0);
        end
        idle();
        step();
        check_eq("drain_svalid", s_rvalid, 0);
        check_eq("drain_hold",   s_rdata, 8'h08);
        check_eq("drain_empty",  s_empty, 1);
        check_eq("drain_unf",    s_un, 0);

        rd_en = 1'b1;
        step();
        check_eq("unf_pulse",  s_un, 1);
        check_eq("unf_count",  s_count, 0);
        check_eq("unf_svalid", s_rvalid, 0);
        idle();
        step();
        check_eq("unf_clear", s_un, 0);

        // Empty with both requests: only the write lands
        wr_en = 1'b1; rd_en = 1'b1; wr_data = 8'hA5;
        step();
        check_eq("eboth_unf",    s_un, 1);
        check_eq("eboth_count",  s_count, 1);
        check_eq("eboth_svalid", s_rvalid, 0);
        check_eq("eboth_fvalid", f_rvalid, 1);
        check_eq("eboth_fdata",  f_rdata, 8'hA5);
        idle();
        step();
        check_eq("fwft_hold", f_rdata, 8'hA5);
        rd_en = 1'b1;
        step();
        check_eq("fwft_pop_empty", f_empty, 1);
        check_eq("fwft_pop_valid", f_rvalid, 0);
        check_eq("fwft_pop_data",  f_rdata, 0);
        check_eq("std_pop_data",   s_rdata, 8'hA5);
        idle();

        for (int i = 0; i < 8; i++) begin
            wr_en = 1'b1; wr_data = 8'(8'h10 + i);
            step();
        end
        check_eq("refill_full", s_full, 1);
        // Full with both requests: only the read lands
        rd_en = 1'b1; wr_data = 8'hEE;
        step();
        check_eq("fboth_ovf",   s_ov, 1);
        check_eq("fboth_unf",   s_un, 0);
        check_eq("fboth_count", s_count, 7);
        check_eq("fboth_sdata", s_rdata, 8'h10);
        check_eq("fboth_fdata", f_rdata, 8'h11);
        wr_en = 1'b0;
        step(); step();
        check_eq("pre_flush_count", s_count, 5);
        check_eq("pre_flush_sdata", s_rdata, 8'h12);

        flush = 1'b1; wr_en = 1'b1; rd_en = 1'b1; wr_data = 8'h77;
        step();
        check_eq("flush_count",  s_count, 0);
        check_eq("flush_empty",  s_empty, 1);
        check_eq("flush_ovf",    s_ov, 0);
        check_eq("flush_unf",    s_un, 0);
        check_eq("flush_svalid", s_rvalid, 0);
        check_eq("flush_sdata",  s_rdata, 8'h12);
        check_eq("flush_fvalid", f_rvalid, 0);
        check_eq("flush_fdata",  f_rdata, 0);
        idle();

        for (int i = 0; i < 3; i++) begin
            wr_en = 1'b1; wr_data = 8'(8'h30 + i);
            step();
        end
        check_eq("pre_rst_count", s_count, 3);
        reset = 1'b1; flush = 1'b1; rd_en = 1'b1;
        step();
        check_eq("rstfl_count",  s_count, 0);
        check_eq("rstfl_empty",  s_empty, 1);
        check_eq("rstfl_aempty", s_aempty, 1);
        check_eq("rstfl_full",   s_full, 0);
        check_eq("rstfl_afull",  s_afull, 0);
        check_eq("rstfl_svalid", s_rvalid, 0);
        check_eq("rstfl_sdata",  s_rdata, 0);
        check_eq("rstfl_fdata",  f_rdata, 0);
        check_eq("rstfl_ovf",    s_ov, 0);
        idle();
        step();

        last_std = 8'h00;
        for (int i = 0; i < 4; i++) op(1'b1, 1'b0, 8'(8'h40 + i));
        for (int i = 0; i < 24; i++) op(1'b1, 1'b1, 8'(8'h50 + i));
        for (int i = 0; i < 120; i++) op(($urandom_range(0, 3) != 0), ($urandom_range(0, 3) == 0), 8'($urandom));
        for (int i = 0; i < 120; i++) op(($urandom_range(0, 3) == 0), ($urandom_range(0, 3) != 0), 8'($urandom));
        for (int i = 0; i < 120; i++) op(1'($urandom), 1'($urandom), 8'($urandom));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
